// File: rtl/userkey_irq_ctrl_if.sv
`default_nettype none
// =============================================================================
// userkey_irq_ctrl_if : register bus and interrupt line of the user-key block
// Revision: 1.0
// =============================================================================
interface userkey_irq_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        key_irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  key_irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output key_irq
    );
endinterface
`default_nettype wire

// File: rtl/userkey_irq_ctrl.sv
`default_nettype none
// =============================================================================
// userkey_irq_ctrl : user-key synchroniser/debouncer with W1C pending, mask and
//                    one level interrupt. Optional auto-repeat: USERKEY_AUTOREPEAT_EN
// Revision: 1.0
// =============================================================================
module userkey_irq_ctrl #(
    parameter int KEY_W         = 8,
    parameter int DB_CYCLES     = 1000000,
    parameter int DB_CNT_W      = 20,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  wire              clk,
    input  wire              clr_n,
    input  wire [KEY_W-1:0]  user_key,
    userkey_irq_ctrl_if.slave bus
);

    localparam logic [1:0] c_ADDR_STATE   = 2'd0;
    localparam logic [1:0] c_ADDR_PENDING = 2'd1;
    localparam logic [1:0] c_ADDR_MASK    = 2'd2;
    localparam logic [1:0] c_ADDR_CTRL    = 2'd3;

`ifdef USERKEY_AUTOREPEAT_EN
    localparam int c_CTRL_W = 3;
`else
    localparam int c_CTRL_W = 2;
`endif

    localparam logic [DB_CNT_W-1:0] c_DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic [KEY_W-1:0]    sync1_q;
    logic [KEY_W-1:0]    sync2_q;
    logic [KEY_W-1:0]    stable_q;
    logic [KEY_W-1:0]    stable_d;
    logic [KEY_W-1:0]    stable_prev_q;
    logic [DB_CNT_W-1:0] db_cnt_q [KEY_W];
    logic [DB_CNT_W-1:0] db_cnt_d [KEY_W];
    logic [KEY_W-1:0]    pending_q;
    logic [KEY_W-1:0]    pending_d;
    logic [KEY_W-1:0]    mask_q;
    logic [KEY_W-1:0]    mask_d;
    logic [c_CTRL_W-1:0] ctrl_q;
    logic [c_CTRL_W-1:0] ctrl_d;
    logic                key_irq_q;
    logic                key_irq_d;

    logic [KEY_W-1:0]    w_level;
    logic [KEY_W-1:0]    w_rise;
    logic [KEY_W-1:0]    w_fall;
    logic [KEY_W-1:0]    w_rpt;
    logic [KEY_W-1:0]    w_ev;
    logic [KEY_W-1:0]    w_clr;
    logic                w_wr_pend;
    logic                w_wr_mask;
    logic                w_wr_ctrl;
    logic [31:0]         w_rdata;

    // Pins are active-low; the synchroniser idles at 1 so reset looks like "all released".
    assign w_level = ~sync2_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= user_key;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < KEY_W; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (w_level[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == c_DB_LAST) begin
                stable_d[i] = w_level[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < KEY_W; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign w_rise = stable_q & ~stable_prev_q;
    assign w_fall = ~stable_q & stable_prev_q;

`ifdef USERKEY_AUTOREPEAT_EN
    localparam int c_RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

    logic [c_RPT_W-1:0] rpt_cnt_q [KEY_W];
    logic [c_RPT_W-1:0] rpt_cnt_d [KEY_W];

    // Counter restarts on the press edge so the first repeat lands a full period later.
    always_comb begin
        w_rpt = '0;
        for (int i = 0; i < KEY_W; i++) begin
            rpt_cnt_d[i] = '0;
            if (stable_q[i] && !w_rise[i] && ctrl_q[2]) begin
                if (rpt_cnt_q[i] == c_RPT_LAST) begin
                    w_rpt[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + c_RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < KEY_W; i++) begin
            if (!clr_n) begin
                rpt_cnt_q[i] <= '0;
            end else begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end
`else
    logic unused_repeat;

    assign w_rpt         = '0;
    assign unused_repeat = ^32'(REPEAT_CYCLES);
`endif

    assign w_ev = w_rise | ({KEY_W{ctrl_q[1]}} & w_fall) | w_rpt;

    assign w_wr_pend = bus.we && (bus.addr == c_ADDR_PENDING);
    assign w_wr_mask = bus.we && (bus.addr == c_ADDR_MASK);
    assign w_wr_ctrl = bus.we && (bus.addr == c_ADDR_CTRL);

    assign w_clr = w_wr_pend ? bus.wdata[KEY_W-1:0] : '0;

    // A new event outranks a same-cycle clear so no edge is ever lost.
    always_comb begin
        pending_d = (pending_q & ~w_clr) | w_ev;
        mask_d    = w_wr_mask ? bus.wdata[KEY_W-1:0] : mask_q;
        ctrl_d    = w_wr_ctrl ? bus.wdata[c_CTRL_W-1:0] : ctrl_q;
        key_irq_d = ctrl_q[0] & (|(pending_q & mask_q));
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            ctrl_q    <= '0;
            key_irq_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ctrl_q    <= ctrl_d;
            key_irq_q <= key_irq_d;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            c_ADDR_STATE:   w_rdata[KEY_W-1:0]    = stable_q;
            c_ADDR_PENDING: w_rdata[KEY_W-1:0]    = pending_q;
            c_ADDR_MASK:    w_rdata[KEY_W-1:0]    = mask_q;
            c_ADDR_CTRL:    w_rdata[c_CTRL_W-1:0] = ctrl_q;
            default:        w_rdata               = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    assign bus.rdata   = w_rdata;
    assign bus.key_irq = key_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_userkey_irq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for userkey_irq_ctrl (DB_CYCLES=4, REPEAT_CYCLES=16).
module tb_userkey_irq_ctrl;

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_MASK  = 2'd2;
    localparam logic [1:0] A_CTRL  = 2'd3;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] user_key;
    int         n_vec = 0;
    int         n_err = 0;

    userkey_irq_ctrl_if bus ();

    userkey_irq_ctrl #(
        .KEY_W         (8),
        .DB_CYCLES     (4),
        .DB_CNT_W      (3),
        .REPEAT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .user_key (user_key),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick(1);
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        clr_n = 1'b0; user_key = 8'h00; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_vec++;
            if (d !== 32'h0) begin n_err++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0); end
        end
        n_vec++;
        if (bus.key_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", bus.key_irq); end
        clr_n = 1'b1;
        tick(5);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_state_early: got %h expected %h", d, 32'h0); end
        tick(1);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'hFF) begin n_err++; $display("FAIL reset_state_6cyc: got %h expected %h", d, 32'hFF); end
        tick(1);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'hFF) begin n_err++; $display("FAIL reset_press_pending: got %h expected %h", d, 32'hFF); end
        user_key = 8'hFF;
        tick(8);
        wr(A_PEND, 32'hFF);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL release_clear_pending: got %h expected %h", d, 32'h0); end
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL release_state: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        user_key = 8'hF7;
        tick(3);
        user_key = 8'hFF;
        tick(10);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL glitch_state: got %h expected %h", d, 32'h0); end
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL glitch_pending: got %h expected %h", d, 32'h0); end
        user_key = 8'hF7;
        tick(5);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL db_state_5cyc: got %h expected %h", d, 32'h0); end
        tick(1);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h08) begin n_err++; $display("FAIL db_state_6cyc: got %h expected %h", d, 32'h08); end
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL db_pending_6cyc: got %h expected %h", d, 32'h0); end
        tick(1);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h08) begin n_err++; $display("FAIL db_pending_7cyc: got %h expected %h", d, 32'h08); end
    endtask

    task automatic test_irq_mask;
        logic [31:0] d;
        wr(A_MASK, 32'h08);
        tick(2);
        n_vec++;
        if (bus.key_irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled: got %b expected 0", bus.key_irq); end
        rd(A_MASK, d);
        n_vec++;
        if (d !== 32'h08) begin n_err++; $display("FAIL mask_readback: got %h expected %h", d, 32'h08); end
        wr(A_CTRL, 32'h1);
        n_vec++;
        if (bus.key_irq !== 1'b0) begin n_err++; $display("FAIL irq_enable_same_edge: got %b expected 0", bus.key_irq); end
        tick(1);
        n_vec++;
        if (bus.key_irq !== 1'b1) begin n_err++; $display("FAIL irq_enable_next: got %b expected 1", bus.key_irq); end
        wr(A_PEND, 32'h08);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL irq_w1c_pending: got %h expected %h", d, 32'h0); end
        n_vec++;
        if (bus.key_irq !== 1'b1) begin n_err++; $display("FAIL irq_clear_same_edge: got %b expected 1", bus.key_irq); end
        tick(1);
        n_vec++;
        if (bus.key_irq !== 1'b0) begin n_err++; $display("FAIL irq_clear_next: got %b expected 0", bus.key_irq); end
        user_key = 8'hFF;
        tick(8);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL press_only_release: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_both_edge;
        logic [31:0] d;
        wr(A_CTRL, 32'hFFFF_FFFB);
        rd(A_CTRL, d);
        n_vec++;
        if (d !== 32'h3) begin n_err++; $display("FAIL ctrl_readback: got %h expected %h", d, 32'h3); end
        user_key = 8'hFD;
        tick(7);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h02) begin n_err++; $display("FAIL both_press_pending: got %h expected %h", d, 32'h02); end
        wr(A_PEND, 32'h02);
        user_key = 8'hFF;
        tick(6);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL both_release_state: got %h expected %h", d, 32'h0); end
        wr(A_PEND, 32'h02);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h02) begin n_err++; $display("FAIL set_wins: got %h expected %h", d, 32'h02); end
        wr(A_PEND, 32'h02);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL both_final_clear: got %h expected %h", d, 32'h0); end
        wr(A_STATE, 32'hFF);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL state_readonly: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_simul_and_reset;
        logic [31:0] d;
        wr(A_MASK, 32'h81);
        wr(A_CTRL, 32'h1);
        user_key = 8'h7E;
        tick(7);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h81) begin n_err++; $display("FAIL simul_pending: got %h expected %h", d, 32'h81); end
        tick(1);
        n_vec++;
        if (bus.key_irq !== 1'b1) begin n_err++; $display("FAIL simul_irq: got %b expected 1", bus.key_irq); end
        user_key = 8'h3E;
        tick(4);
        clr_n = 1'b0;
        tick(1);
        clr_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_vec++;
            if (d !== 32'h0) begin n_err++; $display("FAIL midreset_reg%0d: got %h expected %h", a, d, 32'h0); end
        end
        n_vec++;
        if (bus.key_irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b expected 0", bus.key_irq); end
        tick(5);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL postreset_state_5cyc: got %h expected %h", d, 32'h0); end
        tick(1);
        rd(A_STATE, d);
        n_vec++;
        if (d !== 32'hC1) begin n_err++; $display("FAIL postreset_state_6cyc: got %h expected %h", d, 32'hC1); end
        user_key = 8'hFF;
        tick(8);
        wr(A_PEND, 32'hFF);
    endtask

`ifdef USERKEY_AUTOREPEAT_EN
    task automatic test_autorepeat;
        logic [31:0] d;
        wr(A_CTRL, 32'h5);
        wr(A_MASK, 32'h01);
        user_key = 8'hFE;
        tick(7);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h01) begin n_err++; $display("FAIL rpt_press: got %h expected %h", d, 32'h01); end
        wr(A_PEND, 32'h01);
        for (int r = 0; r < 3; r++) begin
            tick(14);
            rd(A_PEND, d);
            n_vec++;
            if (d !== 32'h0) begin n_err++; $display("FAIL rpt%0d_early: got %h expected %h", r, d, 32'h0); end
            tick(1);
            rd(A_PEND, d);
            n_vec++;
            if (d !== 32'h01) begin n_err++; $display("FAIL rpt%0d_set: got %h expected %h", r, d, 32'h01); end
            wr(A_PEND, 32'h01);
        end
        user_key = 8'hFF;
        tick(40);
        rd(A_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL rpt_after_release: got %h expected %h", d, 32'h0); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_debounce();
        test_irq_mask();
        test_both_edge();
        test_simul_and_reset();
`ifdef USERKEY_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
